// File: rtl/fetch_exec_if.sv
// ---------------------------------------------------------------------------
// fetch_exec_if
// Bundles the upstream request/completion signals and the instruction-memory
// read port of fetch_exec_unit.
//
// Handshake semantics (the only protocol rules of this bundle):
//   * start is a one-cycle request. It is accepted on a rising clock edge
//     only while busy=0. A start seen while busy=1 is discarded and counted
//     in drop_cnt. pc_in is sampled on the accepting edge.
//   * done is a level. It falls on the accepting edge and rises once when
//     the instruction finishes. It then stays high until the next accepted
//     start. err qualifies done: it is 1 when the fetch timed out.
//   * mem_rd is held high for every FETCH cycle. A mem_ready strobe in any
//     of those cycles completes the read, and mem_rdata is taken on that
//     same edge. mem_ready outside FETCH has no effect.
//
// Ports
//   start, pc_in, mem_rdata, mem_ready           : master -> slave
//   mem_addr, mem_rd, instr, busy, done, err,
//   drop_cnt, dbg_state                          : slave -> master
// dbg_state exposes the controller state for observation only.
// ---------------------------------------------------------------------------
interface fetch_exec_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] pc_in;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [DATA_W-1:0] instr;
   logic              busy;
   logic              done;
   logic              err;
   logic [7:0]        drop_cnt;
   logic [2:0]        dbg_state;

   modport master (
      output start, pc_in, mem_rdata, mem_ready,
      input  mem_addr, mem_rd, instr, busy, done, err, drop_cnt, dbg_state
   );

   modport slave (
      input  start, pc_in, mem_rdata, mem_ready,
      output mem_addr, mem_rd, instr, busy, done, err, drop_cnt, dbg_state
   );
endinterface

// File: rtl/fetch_exec_unit.sv
// ---------------------------------------------------------------------------
// fetch_exec_unit
// Handles one instruction per accepted start pulse. It fetches the word at
// pc_in, with a timeout if memory never answers. It then decodes the word
// and spends opcode[1:0]+1 cycles in EXEC. Finally it signals completion
// with a done level that persists until the next request.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset. Assertion acts immediately;
//            release is re-timed through two flops.
//   bus    : fetch_exec_if.slave (request, memory read port, status outputs)
// ---------------------------------------------------------------------------
module fetch_exec_unit #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_exec_if.slave  bus
);

   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_DECODE   = 3'd2,
      S_EXEC     = 3'd3,
      S_COMPLETE = 3'd4
   } state_t;

   // Reset synchroniser. Assertion clears both flops at once. Release only
   // reaches the core after two clean rising edges.
   logic [1:0] rst_sync_q;
   logic       rst_core_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_core_n = rst_sync_q[1];

   state_t            state_q,    state_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q,   mem_rd_d;
   logic [DATA_W-1:0] instr_q,    instr_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic              err_q,      err_d;
   logic [7:0]        drop_q,     drop_d;
   logic [WAIT_W-1:0] wait_q,     wait_d;
   logic [2:0]        exec_q,     exec_d;

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = mem_rd_q;
      instr_d    = instr_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      drop_d     = drop_q;
      wait_d     = wait_q;
      exec_d     = exec_q;

      // Any request outside IDLE is lost. This includes the COMPLETE cycle,
      // so a start is only accepted after busy has actually fallen.
      if (bus.start && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_FETCH;
               mem_addr_d = bus.pc_in;
               mem_rd_d   = 1'b1;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               wait_d     = '0;
            end
         end

         S_FETCH: begin
            // mem_ready is tested first, so a response in the last allowed
            // cycle still counts as a good fetch.
            if (bus.mem_ready) begin
               instr_d  = bus.mem_rdata;
               mem_rd_d = 1'b0;
               state_d  = S_DECODE;
            end else if (wait_q == WAIT_W'(TIMEOUT)) begin
               err_d    = 1'b1;
               mem_rd_d = 1'b0;
               state_d  = S_COMPLETE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         S_DECODE: begin
            exec_d  = {1'b0, instr_q[DATA_W-3:DATA_W-4]} + 3'd1;
            state_d = S_EXEC;
         end

         S_EXEC: begin
            exec_d = exec_q - 3'd1;
            if (exec_q == 3'd1) state_d = S_COMPLETE;
         end

         S_COMPLETE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d  = S_IDLE;
            mem_rd_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state_q    <= S_IDLE;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         instr_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         drop_q     <= 8'd0;
         wait_q     <= '0;
         exec_q     <= 3'd0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         instr_q    <= instr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         drop_q     <= drop_d;
         wait_q     <= wait_d;
         exec_q     <= exec_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.instr     = instr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.drop_cnt  = drop_q;
   assign bus.dbg_state = state_q;

endmodule
